// File: rtl/im2col_stream.sv
// rtl/im2col_stream.sv - streaming im2col engine: frame buffer load, then one column per beat
module im2col_stream #(
    parameter int IMAGE_WIDTH  = 20,
    parameter int IMAGE_HEIGHT = 20,
    parameter int CHANNELS     = 1,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 8,
    parameter int H_POS        = (IMAGE_WIDTH  - KERNEL_SIZE + 2*PADDING)/STRIDE + 1,
    parameter int V_POS        = (IMAGE_HEIGHT - KERNEL_SIZE + 2*PADDING)/STRIDE + 1,
    parameter int COL_LEN      = KERNEL_SIZE*KERNEL_SIZE*CHANNELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COL_LEN*DATA_WIDTH-1:0] out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int PIX_W = CHANNELS*DATA_WIDTH;
    localparam int COL_W = COL_LEN*DATA_WIDTH;
    localparam int DEPTH = IMAGE_HEIGHT*IMAGE_WIDTH;
    localparam int AW    = (DEPTH > 1)        ? $clog2(DEPTH)        : 1;
    localparam int XW    = (IMAGE_WIDTH > 1)  ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int OXW   = (H_POS > 1)        ? $clog2(H_POS)        : 1;
    localparam int OYW   = (V_POS > 1)        ? $clog2(V_POS)        : 1;

    typedef enum logic {
        S_LOAD,
        S_EMIT
    } state_t;

    state_t             state;
    logic [XW-1:0]      x_cnt;
    logic [YW-1:0]      y_cnt;
    logic [OXW-1:0]     ox_cnt;
    logic [OYW-1:0]     oy_cnt;
    logic [PIX_W-1:0]   frame_mem [DEPTH];

    logic               accept;
    logic               last_pix;
    logic               xfer;
    logic               last_col;
    logic [AW-1:0]      wr_addr;
    logic [OXW-1:0]     nxt_ox;
    logic [OYW-1:0]     nxt_oy;
    logic               nxt_last;
    logic [COL_W-1:0]   col_data;

    int                 iy;
    int                 ix;
    int                 e;
    logic [AW-1:0]      rd_addr;
    logic [PIX_W-1:0]   pix;

    assign accept   = in_valid & in_ready;
    assign last_pix = (x_cnt == XW'(IMAGE_WIDTH - 1)) && (y_cnt == YW'(IMAGE_HEIGHT - 1));
    assign xfer     = out_valid & out_ready;
    assign last_col = (ox_cnt == OXW'(H_POS - 1)) && (oy_cnt == OYW'(V_POS - 1));
    assign wr_addr  = AW'(int'(y_cnt) * IMAGE_WIDTH + int'(x_cnt));

    // Index of the column to be registered next: column 0 when leaving LOAD, else the successor
    always_comb begin
        nxt_ox = '0;
        nxt_oy = '0;
        if (state == S_EMIT) begin
            if (ox_cnt == OXW'(H_POS - 1)) begin
                nxt_ox = '0;
                nxt_oy = oy_cnt + OYW'(1);
            end else begin
                nxt_ox = ox_cnt + OXW'(1);
                nxt_oy = oy_cnt;
            end
        end
    end

    assign nxt_last = (nxt_ox == OXW'(H_POS - 1)) && (nxt_oy == OYW'(V_POS - 1));

    // Gather the next column; the pixel being written this cycle is forwarded so column 0
    // can be registered on the same edge that accepts the final pixel
    always_comb begin
        col_data = '0;
        iy       = 0;
        ix       = 0;
        e        = 0;
        rd_addr  = '0;
        pix      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
                for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                    iy      = int'(nxt_oy) * STRIDE + ky - PADDING;
                    ix      = int'(nxt_ox) * STRIDE + kx - PADDING;
                    e       = (c * KERNEL_SIZE + ky) * KERNEL_SIZE + kx;
                    rd_addr = AW'(iy * IMAGE_WIDTH + ix);
                    pix     = (accept && (rd_addr == wr_addr)) ? in_data : frame_mem[rd_addr];
                    if ((iy >= 0) && (iy < IMAGE_HEIGHT) && (ix >= 0) && (ix < IMAGE_WIDTH)) begin
                        col_data[e*DATA_WIDTH +: DATA_WIDTH] = pix[c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Frame buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_mem[wr_addr] <= in_data;
        end
    end

    // LOAD/EMIT controller with registered handshake and column outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            x_cnt     <= '0;
            y_cnt     <= '0;
            ox_cnt    <= '0;
            oy_cnt    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (last_pix) begin
                            x_cnt     <= '0;
                            y_cnt     <= '0;
                            ox_cnt    <= '0;
                            oy_cnt    <= '0;
                            state     <= S_EMIT;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_data  <= col_data;
                            out_last  <= nxt_last;
                        end else if (x_cnt == XW'(IMAGE_WIDTH - 1)) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + YW'(1);
                        end else begin
                            x_cnt <= x_cnt + XW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (xfer) begin
                        if (last_col) begin
                            state     <= S_LOAD;
                            ox_cnt    <= '0;
                            oy_cnt    <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            ox_cnt   <= nxt_ox;
                            oy_cnt   <= nxt_oy;
                            out_data <= col_data;
                            out_last <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im2col_stream.sv
// tb/tb_im2col_stream.sv - self-checking bench for im2col_stream over three 4x4 configurations
module tb_im2col_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   out_last;
    logic [2:0]   busy;
    logic [143:0] d0;
    logic [71:0]  d1;
    logic [71:0]  d2;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    logic [15:0]  frame_px [16];
    logic [143:0] cap      [3][16];
    logic         cap_last [3][16];
    int           col_cnt     [3];
    int           frames_done [3];
    int           frames_expected = 0;
    bit           stall     [3];
    logic [143:0] hold_data [3];
    logic         hold_last [3];

    typedef struct {
        int inst;
        int col;
        int base;
        int last;
        int el [9];
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    // dut0: C=2, S=1, P=0 ; dut1: C=1, S=1, P=1 ; dut2: C=1, S=2, P=1
    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNELS(2), .KERNEL_SIZE(3),
                    .STRIDE(1), .PADDING(0), .DATA_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(d0), .out_last(out_last[0]), .busy(busy[0]));

    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNELS(1), .KERNEL_SIZE(3),
                    .STRIDE(1), .PADDING(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(d1), .out_last(out_last[1]), .busy(busy[1]));

    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNELS(1), .KERNEL_SIZE(3),
                    .STRIDE(2), .PADDING(1), .DATA_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data[7:0]), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(d2), .out_last(out_last[2]), .busy(busy[2]));

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [143:0] data_of(input int i);
        if (i == 0) return d0;
        if (i == 1) return {72'd0, d1};
        return {72'd0, d2};
    endfunction

    function automatic int stride_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int pad_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int hpos_of(input int i);
        return (4 - 3 + 2*pad_of(i)) / stride_of(i) + 1;
    endfunction

    function automatic int ncols_of(input int i);
        return hpos_of(i) * hpos_of(i);
    endfunction

    // Reference column straight from the im2col definition over the stored frame
    function automatic logic [143:0] exp_col(input int i, input int n);
        logic [143:0] r;
        logic [15:0]  px;
        int nel, ox, oy, c, ky, kx, iy, ix;
        r   = '0;
        nel = (i == 0) ? 18 : 9;
        ox  = n % hpos_of(i);
        oy  = n / hpos_of(i);
        for (int el = 0; el < nel; el++) begin
            c  = el / 9;
            ky = (el / 3) % 3;
            kx = el % 3;
            iy = oy*stride_of(i) + ky - pad_of(i);
            ix = ox*stride_of(i) + kx - pad_of(i);
            if (iy >= 0 && iy < 4 && ix >= 0 && ix < 4) begin
                px = frame_px[iy*4 + ix];
                r[el*8 +: 8] = px[c*8 +: 8];
            end
        end
        return r;
    endfunction

    // Per-cycle monitor: column contents vs model, stall stability, handshake consistency
    always @(negedge clk) begin
        logic [143:0] dat;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                col_cnt[i] = 0;
                stall[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                dat = data_of(i);
                if (stall[i]) begin
                    chk("stall_valid", out_valid[i], 1);
                    chk("stall_data", dat, hold_data[i]);
                    chk("stall_last", out_last[i], hold_last[i]);
                end
                chk("ready_vs_busy", in_ready[i], !busy[i]);
                chk("valid_vs_busy", out_valid[i], busy[i]);
                if (out_valid[i] && out_ready) begin
                    chk("column", dat, exp_col(i, col_cnt[i]));
                    chk("last_flag", out_last[i], col_cnt[i] == ncols_of(i) - 1);
                    if (col_cnt[i] < 16) begin
                        cap[i][col_cnt[i]]      = dat;
                        cap_last[i][col_cnt[i]] = out_last[i];
                    end
                    col_cnt[i]++;
                    if (out_last[i]) begin
                        frames_done[i]++;
                        col_cnt[i] = 0;
                    end
                end
                stall[i]     = out_valid[i] && !out_ready;
                hold_data[i] = dat;
                hold_last[i] = out_last[i];
            end
        end
    end

    // Downstream ready: always-on or 50% random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", in_ready[i], 1);
            chk("rst_out_valid", out_valid[i], 0);
            chk("rst_out_last", out_last[i], 0);
            chk("rst_out_data", data_of(i), 0);
            chk("rst_busy", busy[i], 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_ready(input int budget);
        while (!(&in_ready) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) chk("timeout_ready", 0, 1);
    endtask

    task automatic load_frame(input bit gaps);
        int  p;
        int  budget;
        bit  acc;
        wait_all_ready(200);
        p      = 0;
        budget = 1000;
        while (p < 16 && budget > 0) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = frame_px[p];
            @(negedge clk);
            acc = in_valid && (&in_ready);
            @(posedge clk);
            #1;
            if (acc) p++;
            budget--;
        end
        in_valid = 1'b0;
        if (budget == 0) chk("timeout_load", 0, 1);
    endtask

    task automatic finish_frame();
        wait_all_ready(2000);
        frames_expected++;
        for (int i = 0; i < 3; i++) chk("frame_count", frames_done[i], frames_expected);
    endtask

    task automatic set_ramp();
        for (int p = 0; p < 16; p++) frame_px[p] = {8'(100 + p), 8'(p)};
    endtask

    task automatic run_table();
        logic [143:0] w;
        for (int t = 0; t < 7; t++) begin
            w = cap[tbl[t].inst][tbl[t].col];
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("tbl%0d_el%0d", t, k), w[(tbl[t].base + k)*8 +: 8], tbl[t].el[k]);
            end
            chk($sformatf("tbl%0d_last", t), cap_last[tbl[t].inst][tbl[t].col], tbl[t].last);
        end
    endtask

    initial begin
        int budget;
        tbl[0] = '{0, 0,  0, 0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}};
        tbl[1] = '{0, 3,  0, 1, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
        tbl[2] = '{0, 0,  9, 0, '{100, 101, 102, 104, 105, 106, 108, 109, 110}};
        tbl[3] = '{1, 0,  0, 0, '{0, 0, 0, 0, 0, 1, 0, 4, 5}};
        tbl[4] = '{1, 15, 0, 1, '{10, 11, 0, 14, 15, 0, 0, 0, 0}};
        tbl[5] = '{2, 0,  0, 0, '{0, 0, 0, 0, 0, 1, 0, 4, 5}};
        tbl[6] = '{2, 1,  0, 0, '{0, 0, 0, 1, 2, 3, 5, 6, 7}};
        for (int i = 0; i < 3; i++) frames_done[i] = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        do_reset();

        // Known ramp frame, full throughput, checked against fixed column values
        set_ramp();
        load_frame(1'b0);
        finish_frame();
        run_table();

        // Random frames with input gaps and random downstream stalls
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < 16; p++) frame_px[p] = 16'($urandom);
            load_frame(1'b1);
            finish_frame();
        end
        rand_ready = 1'b0;

        // Reset after column 1 is transferred, then a fresh ramp frame
        set_ramp();
        @(posedge clk);
        #1;
        load_frame(1'b0);
        budget = 100;
        while (col_cnt[0] != 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("timeout_col1", 0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_out_valid", out_valid[i], 0);
            chk("midrst_in_ready", in_ready[i], 1);
        end
        @(posedge clk);
        #1;
        load_frame(1'b0);
        finish_frame();
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
